// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: issues one FP operation at a time to an external FP ALU.
// It unboxes the operands on accept, waits for the ALU's done, and writes the
// NaN-boxed result back to regfile_fp.
// Optional feature: define FP_TIMEOUT_EN to bound the done wait to TIMEOUT
// cycles. With the macro defined, timeout_err is sticky until reset.
module fp_op_sequencer #(
    parameter int unsigned FLEN    = 32,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [1:0]      op_code,
    input  logic [2:0]      rounding_mode_i,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [4:0]      rd_addr_i,
    output logic            start_add_sub,
    output logic            start_mult,
    output logic            sub,
    output logic [2:0]      rounding_mode,
    output logic [FLEN-1:0] operand_a,
    output logic [FLEN-1:0] operand_b,
    input  logic            done,
    input  logic [FLEN-1:0] result,
    output logic            load_regfile_fp,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_fp_i,
    output logic            busy,
    output logic            timeout_err
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_MOVE = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q;
    logic [2:0]      rm_q;
    logic [4:0]      rd_q;
    logic [FLEN-1:0] opa_q, opb_q, result_q;
    logic            sub_q;
    logic [FLEN-1:0] unbox_a_c, unbox_b_c;
    logic            accept_c;
    logic            wait_expired_c;

    assign accept_c = (state_q == IDLE) && op_valid;

    // Operand unboxing on the way in, NaN-boxing of the result on the way out
    if (FLEN < XLEN) begin : g_box
        localparam logic [FLEN-1:0] CANON_NAN = (FLEN == 64) ? FLEN'(64'h7FF8_0000_0000_0000)
                                                             : FLEN'(32'h7FC0_0000);
        assign unbox_a_c = (&rs1_value[XLEN-1:FLEN]) ? rs1_value[FLEN-1:0] : CANON_NAN;
        assign unbox_b_c = (&rs2_value[XLEN-1:FLEN]) ? rs2_value[FLEN-1:0] : CANON_NAN;
        assign rd_fp_i   = {{(XLEN-FLEN){1'b1}}, result_q};
    end else begin : g_nobox
        assign unbox_a_c = rs1_value[FLEN-1:0];
        assign unbox_b_c = rs2_value[FLEN-1:0];
        assign rd_fp_i   = XLEN'(result_q);
    end

`ifdef FP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_err_q;

    assign wait_expired_c = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_err    = timeout_err_q;

    // WAIT-cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
            if (wait_expired_c && !done) begin
                timeout_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wait_expired_c = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid) state_d = ISSUE;
            ISSUE:   state_d = (op_q == OP_MOVE) ? WRITE : WAIT;
            WAIT: begin
                if (done) begin
                    state_d = WRITE;
                end else if (wait_expired_c) begin
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded control outputs
    always_comb begin
        op_ready        = 1'b0;
        busy            = 1'b1;
        start_add_sub   = 1'b0;
        start_mult      = 1'b0;
        load_regfile_fp = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
            end
            ISSUE: begin
                start_add_sub = (op_q == OP_ADD) || (op_q == OP_SUB);
                start_mult    = (op_q == OP_MUL);
            end
            WRITE:   load_regfile_fp = 1'b1;
            default: ;
        endcase
    end

    // Request latch and result capture (move takes operand_a as its result)
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept_c) begin
                op_q  <= op_code;
                rm_q  <= rounding_mode_i;
                rd_q  <= rd_addr_i;
                opa_q <= unbox_a_c;
                opb_q <= unbox_b_c;
                sub_q <= (op_code == OP_SUB);
            end
            if ((state_q == ISSUE) && (op_q == OP_MOVE)) begin
                result_q <= opa_q;
            end else if ((state_q == WAIT) && done) begin
                result_q <= result;
            end
        end
    end

    assign sub           = sub_q;
    assign rounding_mode = rm_q;
    assign operand_a     = opa_q;
    assign operand_b     = opb_q;
    assign rd_addr       = rd_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer.
// dut32 is FLEN=32 with NaN boxing. dut64 is FLEN=64, XLEN=64 with no boxing.
// Both run in lockstep on shared stimulus.
module tb_fp_op_sequencer;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [2:0]  rm_i;
    logic [63:0] rs1_value, rs2_value;
    logic [4:0]  rd_addr_i;
    logic        done;
    logic [63:0] result;

    logic        op_ready, start_add_sub, start_mult, sub, load_regfile_fp, busy, timeout_err;
    logic [2:0]  rounding_mode;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_addr;
    logic [63:0] rd_fp;

    logic        op_ready_64, start_add_sub_64, start_mult_64, sub_64, load_64, busy_64, timeout_err_64;
    logic [2:0]  rounding_mode_64;
    logic [63:0] operand_a_64, operand_b_64;
    logic [4:0]  rd_addr_64;
    logic [63:0] rd_fp_64;

    int n_tests = 0;
    int n_fail  = 0;

    fp_op_sequencer #(.FLEN(32), .XLEN(64), .TIMEOUT(8)) dut32 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .rounding_mode_i(rm_i), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rd_addr_i(rd_addr_i), .start_add_sub(start_add_sub), .start_mult(start_mult), .sub(sub),
        .rounding_mode(rounding_mode), .operand_a(operand_a), .operand_b(operand_b),
        .done(done), .result(result[31:0]), .load_regfile_fp(load_regfile_fp), .rd_addr(rd_addr),
        .rd_fp_i(rd_fp), .busy(busy), .timeout_err(timeout_err)
    );

    fp_op_sequencer #(.FLEN(64), .XLEN(64), .TIMEOUT(8)) dut64 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready_64),
        .op_code(op_code), .rounding_mode_i(rm_i), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rd_addr_i(rd_addr_i), .start_add_sub(start_add_sub_64), .start_mult(start_mult_64), .sub(sub_64),
        .rounding_mode(rounding_mode_64), .operand_a(operand_a_64), .operand_b(operand_b_64),
        .done(done), .result(result), .load_regfile_fp(load_64), .rd_addr(rd_addr_64),
        .rd_fp_i(rd_fp_64), .busy(busy_64), .timeout_err(timeout_err_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  rd;
        logic [2:0]  rm;
        int          dly;      // done arrives dly cycles after the start pulse
        logic [63:0] res;
        logic [63:0] exp_fp;
        logic [31:0] exp_opa;
        logic [31:0] exp_opb;
        int          exp_as;
        int          exp_mul;
        logic        exp_sub;
        int          exp_lat;  // accept edge to write cycle
    } vec_t;

    typedef struct {
        logic        ready;
        logic        ld_prev;
        int          n_as;
        int          n_mul;
        logic        sub;
        logic [2:0]  rm;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [63:0] opa64;
        int          hold_err;
        logic [63:0] fp;
        logic [63:0] fp64;
        logic [4:0]  addr;
        int          lat;
        logic        got;
    } res_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, keep op_valid high with junk while busy, return at the write cycle
    task automatic run_op(input vec_t v, output res_t r);
        int s;
        s = -1;
        r.n_as = 0; r.n_mul = 0; r.hold_err = 0; r.lat = 0; r.got = 1'b0;
        r.sub = 1'bx; r.rm = 'x; r.opa = 'x; r.opb = 'x; r.opa64 = 'x;
        r.fp = 'x; r.fp64 = 'x; r.addr = 'x;
        @(negedge clk);
        r.ready   = op_ready;
        r.ld_prev = load_regfile_fp;
        op_valid = 1'b1; op_code = v.op; rs1_value = v.rs1; rs2_value = v.rs2;
        rd_addr_i = v.rd; rm_i = v.rm; done = 1'b0;
        for (int k = 1; k <= 40 && !r.got; k++) begin
            @(negedge clk);
            op_code = ~v.op; rs1_value = ~v.rs1; rs2_value = ~v.rs2;
            rd_addr_i = ~v.rd; rm_i = ~v.rm;
            done   = (s > 0) && (v.dly > 0) && (k == s + v.dly);
            result = done ? v.res : 64'h0BAD_0BAD_0BAD_0BAD;
            if (start_add_sub || start_mult) begin
                if (start_add_sub) r.n_as++;
                if (start_mult) r.n_mul++;
                s = k;
                r.sub = sub; r.rm = rounding_mode; r.opa = operand_a; r.opb = operand_b;
                r.opa64 = operand_a_64;
            end else if (s > 0 && !load_regfile_fp) begin
                if (sub !== r.sub || rounding_mode !== r.rm || operand_a !== r.opa || operand_b !== r.opb)
                    r.hold_err++;
            end
            if (load_regfile_fp) begin
                r.got = 1'b1; r.lat = k; r.fp = rd_fp; r.fp64 = rd_fp_64; r.addr = rd_addr;
                op_valid = 1'b0;
            end
        end
        done = 1'b0;
        op_valid = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t w;
    res_t r;
    int   n_ld;
    int   k_idle;

    initial begin
        vecs[0] = '{2'd0, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000, 5'd5,  3'd0, 5,
                    64'h00000000_40400000, 64'hFFFFFFFF_40400000, 32'h3F800000, 32'h40000000, 1, 0, 1'b0, 7};
        vecs[1] = '{2'd3, 64'h00000000_3F800000, 64'hFFFFFFFF_00000000, 5'd7,  3'd1, 0,
                    64'h0, 64'hFFFFFFFF_7FC00000, 32'h7FC00000, 32'h0, 0, 0, 1'b0, 2};
        vecs[2] = '{2'd1, 64'hFFFFFFFF_40A00000, 64'hFFFFFFFF_3F800000, 5'd10, 3'd2, 1,
                    64'h00000000_40800000, 64'hFFFFFFFF_40800000, 32'h40A00000, 32'h3F800000, 1, 0, 1'b1, 3};
        vecs[3] = '{2'd2, 64'hFFFFFFFF_40000000, 64'hFFFFFFFF_40400000, 5'd11, 3'd4, 2,
                    64'h00000000_40C00000, 64'hFFFFFFFF_40C00000, 32'h40000000, 32'h40400000, 0, 1, 1'b0, 4};
        vecs[4] = '{2'd3, 64'hFFFFFFFF_C0490FDB, 64'h0, 5'd31, 3'd7, 0,
                    64'h0, 64'hFFFFFFFF_C0490FDB, 32'hC0490FDB, 32'h0, 0, 0, 1'b0, 2};
        vecs[5] = '{2'd0, 64'hFFFFFFFF_00000000, 64'h7FFFFFFF_12345678, 5'd0,  3'd3, 3,
                    64'h00000000_7FC00000, 64'hFFFFFFFF_7FC00000, 32'h00000000, 32'h7FC00000, 1, 0, 1'b0, 5};

        reset = 1'b1; op_valid = 1'b0; op_code = '0; rm_i = '0; rs1_value = '0; rs2_value = '0;
        rd_addr_i = '0; done = 1'b0; result = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_op_ready", op_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start_as", start_add_sub, 0);
        check("rst_start_mul", start_mult, 0);
        check("rst_load", load_regfile_fp, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_rd_fp", rd_fp, 64'hFFFFFFFF_00000000);
        check("rst_operand_a", operand_a, 0);

        // Table vectors, issued back-to-back
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], r);
            check($sformatf("v%0d_ready", i), r.ready, 1);
            check($sformatf("v%0d_load_prev", i), r.ld_prev, 0);
            check($sformatf("v%0d_load_seen", i), r.got, 1);
            check($sformatf("v%0d_n_add_sub", i), r.n_as, vecs[i].exp_as);
            check($sformatf("v%0d_n_mult", i), r.n_mul, vecs[i].exp_mul);
            check($sformatf("v%0d_rd_fp", i), r.fp, vecs[i].exp_fp);
            check($sformatf("v%0d_rd_addr", i), r.addr, vecs[i].rd);
            check($sformatf("v%0d_latency", i), r.lat, vecs[i].exp_lat);
            if (vecs[i].exp_as + vecs[i].exp_mul > 0) begin
                check($sformatf("v%0d_sub", i), r.sub, vecs[i].exp_sub);
                check($sformatf("v%0d_rm", i), r.rm, vecs[i].rm);
                check($sformatf("v%0d_operand_a", i), r.opa, vecs[i].exp_opa);
                check($sformatf("v%0d_operand_b", i), r.opb, vecs[i].exp_opb);
                check($sformatf("v%0d_hold", i), r.hold_err, 0);
            end
        end

        // FLEN=64: no unboxing, result written exactly
        w = '{2'd2, 64'h400921FB_54442D18, 64'h40000000_00000000, 5'd3, 3'd0, 2,
              64'h401921FB_54442D18, 64'h0, 32'h0, 32'h0, 0, 1, 1'b0, 4};
        run_op(w, r);
        check("f64_mul_rd_fp", r.fp64, 64'h401921FB_54442D18);
        check("f64_mul_operand_a", r.opa64, 64'h400921FB_54442D18);
        check("f64_mul_n_mult", r.n_mul, 1);
        w = '{2'd3, 64'h00000000_3F800000, 64'h0, 5'd4, 3'd0, 0,
              64'h0, 64'h0, 32'h0, 32'h0, 0, 0, 1'b0, 2};
        run_op(w, r);
        check("f64_move_rd_fp", r.fp64, 64'h00000000_3F800000);
        check("f64_move_latency", r.lat, 2);

        // Reset two cycles after the start pulse; a late done must not write
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'd0; rs1_value = 64'hFFFFFFFF_3F800000;
        rs2_value = 64'hFFFFFFFF_40000000; rd_addr_i = 5'd9; rm_i = 3'd0;
        @(negedge clk);
        op_valid = 1'b0;
        check("rstwait_start", start_add_sub, 1);
        n_ld = 0;
        @(negedge clk);
        if (load_regfile_fp) n_ld++;
        reset = 1'b1;
        @(negedge clk);
        if (load_regfile_fp) n_ld++;
        reset = 1'b0;
        check("rstwait_op_ready", op_ready, 1);
        check("rstwait_busy", busy, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            done = (k == 1);
            result = 64'h00000000_40400000;
            if (load_regfile_fp || start_add_sub || start_mult) n_ld++;
        end
        done = 1'b0;
        check("rstwait_no_write", n_ld, 0);
        check("rstwait_rd_fp", rd_fp, 64'hFFFFFFFF_00000000);
        check("rstwait_operand_a", operand_a, 0);
        check("rstwait_op_ready_end", op_ready, 1);

        // Done never arrives
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'd0; rs1_value = 64'hFFFFFFFF_3F800000;
        rs2_value = 64'hFFFFFFFF_3F800000; rd_addr_i = 5'd12; rm_i = 3'd0;
        n_ld = 0;
        k_idle = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            op_valid = 1'b0;
            if (load_regfile_fp) n_ld++;
            if (!busy && k_idle < 0) k_idle = k;
        end
`ifdef FP_TIMEOUT_EN
        check("tmo_idle_cycle", k_idle, 10);
        check("tmo_err", timeout_err, 1);
        check("tmo_no_write", n_ld, 0);
        run_op(vecs[4], r);
        check("tmo_move_rd_fp", r.fp, 64'hFFFFFFFF_C0490FDB);
        check("tmo_err_sticky", timeout_err, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("tmo_err_cleared", timeout_err, 0);
`else
        check("nto_still_busy", busy, 1);
        check("nto_never_idle", k_idle, -1);
        check("nto_err", timeout_err, 0);
        check("nto_no_write", n_ld, 0);
        @(negedge clk);
        done = 1'b1;
        result = 64'h00000000_3F800000;
        @(negedge clk);
        done = 1'b0;
        check("nto_load", load_regfile_fp, 1);
        check("nto_rd_fp", rd_fp, 64'hFFFFFFFF_3F800000);
        check("nto_rd_addr", rd_addr, 5'd12);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/fp_op_sequencer.md
FP_OP_SEQUENCER -- requirements
Module: fp_op_sequencer

Interface
REQ-001 SHALL have parameter FLEN, default 32: FP operand width, 32 or 64.
REQ-002 SHALL have parameter XLEN, default 64: FP register width, XLEN >= FLEN.
REQ-003 SHALL have parameter TIMEOUT, default 64: cycle limit for the done wait (used only with FP_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port op_valid, input, 1: operation request.
REQ-007 SHALL have port op_ready, output, 1: sequencer can accept a request.
REQ-008 SHALL have port op_code, input, 2: 0 add, 1 sub, 2 mul, 3 move.
REQ-009 SHALL have port rounding_mode_i, input, 3: rounding mode for the operation.
REQ-010 SHALL have ports rs1_value and rs2_value, input, XLEN each: source FP registers.
REQ-011 SHALL have port rd_addr_i, input, 5: destination register.
REQ-012 SHALL have ports start_add_sub, start_mult and sub, output, 1 each: controls to the FP ALU.
REQ-013 SHALL have port rounding_mode, output, 3: rounding mode to the FP ALU.
REQ-014 SHALL have ports operand_a and operand_b, output, FLEN each: operands to the FP ALU.
REQ-015 SHALL have ports done, input, 1, and result, input, FLEN: FP ALU completion and result.
REQ-016 SHALL have ports load_regfile_fp, output, 1, rd_addr, output, 5, and rd_fp_i, output, XLEN: write-back to regfile_fp.
REQ-017 SHALL have ports busy, output, 1, and timeout_err, output, 1: status.

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, WAIT and WRITE.
REQ-019 SHALL accept a request in IDLE when op_valid && op_ready; op_ready SHALL be 1 only in IDLE.
REQ-020 SHALL latch op_code, rounding_mode_i, rd_addr_i and the unboxed operands on accept, then go to ISSUE.
REQ-021 SHALL unbox each operand when FLEN < XLEN: if bits [XLEN-1:FLEN] are all ones, take [FLEN-1:0]; otherwise substitute canonical NaN (0x7FC00000 for FLEN=32).
REQ-022 SHALL, in ISSUE, pulse exactly one of start_add_sub (op 0/1) or start_mult (op 2) for one cycle, with sub=1 only for op 1, then go to WAIT.
REQ-023 SHALL go from ISSUE directly to WRITE for op 3 (move), with no start pulse and the result equal to operand_a.
REQ-024 SHALL, in WAIT, capture result into an internal register on the cycle done=1, then go to WRITE; done SHALL be ignored in all other states.
REQ-025 SHALL, in WRITE, assert load_regfile_fp for exactly one cycle with rd_fp_i = {ones[XLEN-FLEN], captured result} and rd_addr = latched destination, then go to IDLE.
REQ-026 SHALL hold operand_a, operand_b, sub and rounding_mode stable from ISSUE through WAIT.
REQ-027 SHALL drive busy = (state != IDLE).
REQ-028 SHALL give a minimum accept-to-write latency of 2 cycles for move and 3 cycles for arithmetic when done arrives in the first WAIT cycle.
REQ-029 SHALL treat op_valid as don't-care while busy; no request is queued.
REQ-030 SHALL support back-to-back operations: a new accept is possible in the cycle after WRITE.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, override all other inputs, including mid-operation: state IDLE, start pulses 0, load_regfile_fp 0, timeout_err 0, all datapath registers 0.
REQ-032 SHALL write no register for an operation interrupted by reset.
REQ-033 SHALL present these outputs in the cycle after reset deasserts: op_ready 1, busy 0.

Configuration
REQ-034 SHALL, with macro FP_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT without done, go to IDLE without write-back and set timeout_err sticky until reset.
REQ-035 SHALL, without FP_TIMEOUT_EN, wait in WAIT indefinitely for done; timeout_err SHALL be constant 0 and no counter SHALL exist.

Verification
REQ-036 SHALL cover add: FLEN=32, rs1=0xFFFFFFFF_3F800000, rs2=0xFFFFFFFF_40000000, op 0, done after 5 cycles with result 0x40400000 -> one start_add_sub pulse with sub=0, then load_regfile_fp with rd_fp_i=0xFFFFFFFF_40400000.
REQ-037 SHALL cover unboxing: rs1=0x00000000_3F800000, op 3 -> rd_fp_i=0xFFFFFFFF_7FC00000 two cycles after accept, with no start pulses.
REQ-038 SHALL cover sub then mul back-to-back: op 1 then op 2 -> sub=1 with start_add_sub, then start_mult with sub=0; two separate one-cycle writes to the correct rd_addr values.
REQ-039 SHALL cover reset in WAIT: reset asserted two cycles after the start pulse, done arriving later -> no load_regfile_fp, op_ready=1 after reset.
REQ-040 SHALL cover timeout: FP_TIMEOUT_EN defined, TIMEOUT=8, done never asserted -> return to IDLE after 8 WAIT cycles, timeout_err=1, no write-back.
REQ-041 SHALL cover FLEN=64: XLEN=64, op 2 -> no boxing, and rd_fp_i equals result exactly.
